uart_credits_rx: RTL

- UART receiver that sits directly downstream of the credits transmitter. It consumes the serial tx line, either looped back on-chip or via an external link.
- Recovers 8N1 bytes using mid-bit 3-sample majority voting.
- Buffers received bytes in a small FIFO and presents them on a valid/ready interface to the debug/self-test logic.
- Flags framing errors and FIFO overruns.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_credits_rx_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_credits_rx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-rate defaults and receiver state encoding
package uart_pkg;

    // Line-rate defaults shared with the credits transmitter.
    localparam int CLK_FREQ     = 10_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int SYMBOL_COUNT = CLK_FREQ / BAUD_RATE;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_credits_rx_if.sv
// rtl/uart_credits_rx_if.sv - received-byte stream and status flags of the credits receiver
interface uart_credits_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // Receiver side: produces bytes and status, consumes ready.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ready
    );

    // Consumer side: debug/self-test logic.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous FIFO holding received bytes
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_credits_rx.sv
// rtl/uart_credits_rx.sv - 8N1 UART receiver with majority voting, byte FIFO and error flags
module uart_credits_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = uart_pkg::CLK_FREQ,
    parameter int BAUD_RATE    = uart_pkg::BAUD_RATE,
    parameter int SYMBOL_COUNT = CLK_FREQ / BAUD_RATE,
    parameter int HALF_COUNT   = SYMBOL_COUNT / 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    uart_credits_rx_if.master    bus
);

    localparam int CNT_W = $clog2(SYMBOL_COUNT);

    logic             rx_meta;
    logic             rx_s;
    logic             rx_s_d;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_nxt;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_nxt;
    logic             samp0;
    logic             samp1;
    logic             vote;
    logic             decide;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             frame_err_nxt;
    logic             overrun_nxt;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Capture the two vote samples ahead of the decision point; the third is live rx_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0 <= 1'b0;
            samp1 <= 1'b0;
        end else begin
            if (clk_cnt == CNT_W'(HALF_COUNT - 1)) samp0 <= rx_s;
            if (clk_cnt == CNT_W'(HALF_COUNT))     samp1 <= rx_s;
        end
    end

    assign vote   = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign decide = (state == RX_START || state == RX_DATA || state == RX_STOP)
                    && (clk_cnt == CNT_W'(HALF_COUNT + 1));
    assign pop    = bus.rx_valid & bus.rx_ready;

    // State, bit timing and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            bus.frame_err <= frame_err_nxt;
            bus.overrun   <= overrun_nxt;
        end
    end

    // Frame sequencing: start qualification, LSB-first data, stop check and error recovery.
    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = (clk_cnt == CNT_W'(SYMBOL_COUNT - 1)) ? '0 : clk_cnt + 1'b1;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        case (state)
            RX_IDLE: begin
                clk_cnt_nxt = '0;
                if (rx_s_d && !rx_s) state_nxt = RX_START;
            end
            RX_START: begin
                if (decide) begin
                    if (vote) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt   = RX_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            RX_DATA: begin
                if (decide) begin
                    shift_nxt   = {vote, shift_reg[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (decide) begin
                    if (vote) begin
                        if (!fifo_full || pop) push = 1'b1;
                        else                   overrun_nxt = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                clk_cnt_nxt = '0;
                if (rx_s) state_nxt = RX_IDLE;
            end
            default: begin
                state_nxt   = RX_IDLE;
                clk_cnt_nxt = '0;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .head      (bus.rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.rx_valid = !fifo_empty;
    assign bus.busy     = (state != RX_IDLE);

endmodule
